// File: rtl/als_display_saida.sv
// Output-register display driver: detects changes on s, converts the byte to BCD with a
// one-iteration-per-clock double-dabble engine, and scans three 7-segment digits with leading-zero blanking.
module als_display_saida #(
  parameter int REFRESH_DIV    = 1000,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic [11:0] bcd,
  output logic        busy
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  last_val_q, last_val_d;
  logic [19:0] shreg_q, shreg_d;
  logic [2:0]  iter_q, iter_d;
  logic [11:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]  dig_idx_q, dig_idx_d;

  logic [19:0] adj;
  logic [19:0] shifted;

  // Active-low gfedcba patterns; anything outside 0..9 is dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] r;
    case (nib)
      4'd0:    r = 7'b1000000;
      4'd1:    r = 7'b1111001;
      4'd2:    r = 7'b0100100;
      4'd3:    r = 7'b0110000;
      4'd4:    r = 7'b0011001;
      4'd5:    r = 7'b0010010;
      4'd6:    r = 7'b0000010;
      4'd7:    r = 7'b1111000;
      4'd8:    r = 7'b0000000;
      4'd9:    r = 7'b0010000;
      default: r = SEG_OFF;
    endcase
    return r;
  endfunction

  // Double-dabble step: add 3 to every BCD nibble >= 5, then shift the whole register.
  always_comb begin
    adj = shreg_q;
    for (int i = 0; i < 3; i++) begin
      if (shreg_q[8 + 4*i +: 4] >= 4'd5) begin
        adj[8 + 4*i +: 4] = shreg_q[8 + 4*i +: 4] + 4'd3;
      end
    end
    shifted = adj << 1;
  end

  always_comb begin
    state_d    = state_q;
    last_val_d = last_val_q;
    shreg_d    = shreg_q;
    iter_d     = iter_q;
    bcd_d      = bcd_q;
    case (state_q)
      IDLE: begin
        if (s != last_val_q) begin
          last_val_d = s;
          shreg_d    = {12'h000, s};
          iter_d     = 3'd0;
          state_d    = CONV;
        end
      end
      CONV: begin
        shreg_d = shifted;
        iter_d  = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          bcd_d   = shifted[19:8];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ref_cnt_d = ref_cnt_q + 1'b1;
    dig_idx_d = dig_idx_q;
    if (ref_cnt_q == CNT_MAX) begin
      ref_cnt_d = '0;
      dig_idx_d = (dig_idx_q == 2'd2) ? 2'd0 : dig_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_val_q <= 8'h00;
      shreg_q    <= 20'h00000;
      iter_q     <= 3'd0;
      bcd_q      <= 12'h000;
      ref_cnt_q  <= '0;
      dig_idx_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      last_val_q <= last_val_d;
      shreg_q    <= shreg_d;
      iter_q     <= iter_d;
      bcd_q      <= bcd_d;
      ref_cnt_q  <= ref_cnt_d;
      dig_idx_q  <= dig_idx_d;
    end
  end

  logic [6:0] seg_raw;
  logic [2:0] an_raw;
  logic       hund_zero;
  logic       tens_zero;

  assign hund_zero = (bcd_q[11:8] == 4'd0);
  assign tens_zero = (bcd_q[7:4] == 4'd0);

  // Blanking only hides segments; the digit enable stays asserted.
  always_comb begin
    seg_raw = SEG_OFF;
    an_raw  = 3'b111;
    case (dig_idx_q)
      2'd0: begin
        an_raw  = 3'b110;
        seg_raw = seg_decode(bcd_q[3:0]);
      end
      2'd1: begin
        an_raw  = 3'b101;
        seg_raw = (hund_zero && tens_zero) ? SEG_OFF : seg_decode(bcd_q[7:4]);
      end
      2'd2: begin
        an_raw  = 3'b011;
        seg_raw = hund_zero ? SEG_OFF : seg_decode(bcd_q[11:8]);
      end
      default: begin
        an_raw  = 3'b111;
        seg_raw = SEG_OFF;
      end
    endcase
  end

  generate
    if (DIG_ACTIVE_LOW) begin : g_act_low
      assign seg = seg_raw;
      assign an  = an_raw;
    end else begin : g_act_high
      assign seg = ~seg_raw;
      assign an  = ~an_raw;
    end
  endgenerate

  assign bcd  = bcd_q;
  assign busy = (state_q == CONV);

endmodule
